tile_reg_file: RTL and testbench

- Register storage for all tile layers. Sits directly upstream of the tile register field decoder and drives its packed `tile_reg_values` bus.
- The host (MCU/CPU bus bridge) writes and reads registers through a simple synchronous bus.
- Writes land in a staging copy. The staging copy is transferred to the active copy once per frame, at vblank start, so register changes never tear a frame mid-scan.

---
 rtl/tile_reg_file.sv | 150 +++++++++++++++
 tb/tb_tile_reg_file.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tile_reg_file.sv
// ---------------------------------------------------------------------------
// tile_reg_file
//   Register storage for all tile layers. Drives the packed tile_reg_values
//   bus of the tile register field decoder and gives the host a simple
//   synchronous read/write port with per-byte write enables.
//
// Build option (macro TILE_REG_SHADOW_EN):
//   defined   - host writes land in a staging copy. Staging is copied into the
//               active copy at the first vblank rise after a write, so a frame
//               never sees a half-updated register set.
//   undefined - only one copy is kept. Writes go straight to the active copy,
//               reads return the active copy, vblank is ignored and
//               update_pending is tied to 0.
//
// Ports:
//   clk             in   system clock
//   reset           in   asynchronous active-high reset
//   addr            in   register select {layer[4:3], reg[2:0]}
//   wr              in   write strobe, one write per cycle
//   rd              in   read strobe; data_out is valid on the next cycle
//   be              in   byte enables: be[1] -> bits 15:8, be[0] -> bits 7:0
//   data_in         in   write data
//   data_out        out  read data, held while rd is low
//   vblank          in   vertical blank level from the display timing block
//   tile_reg_values out  active registers, packed; layer i reg j at
//                        [(i*NUM_REGS+j)*DATA_WIDTH +: DATA_WIDTH]
//   update_pending  out  staging holds writes not yet made active
// ---------------------------------------------------------------------------
module tile_reg_file #(
  parameter int NUM_LAYERS = 4,
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [ADDR_WIDTH-1:0]                  addr,
  input  logic                                   wr,
  input  logic                                   rd,
  input  logic [1:0]                             be,
  input  logic [DATA_WIDTH-1:0]                  data_in,
  output logic [DATA_WIDTH-1:0]                  data_out,
  input  logic                                   vblank,
  output logic [NUM_LAYERS*NUM_REGS*DATA_WIDTH-1:0] tile_reg_values,
  output logic                                   update_pending
);

  localparam int NUM_ENTRIES = NUM_LAYERS * NUM_REGS;
  localparam int LO_WIDTH    = DATA_WIDTH / 2;
  localparam int HI_WIDTH    = DATA_WIDTH - LO_WIDTH;

  // Packed so that entry 0 sits at the LSBs and the array maps bit-for-bit
  // onto tile_reg_values.
  typedef logic [NUM_ENTRIES-1:0][DATA_WIDTH-1:0] reg_bank_t;

  logic [DATA_WIDTH-1:0] lane_mask;
  logic                  write_hit;
  logic [DATA_WIDTH-1:0] data_out_q;
  reg_bank_t             active_q, active_d;

  assign lane_mask = {{HI_WIDTH{be[1]}}, {LO_WIDTH{be[0]}}};
  // A write with no byte lanes enabled is a no-op in every respect.
  assign write_hit = wr && (be != 2'b00);

  assign tile_reg_values = active_q;
  assign data_out        = data_out_q;

`ifdef TILE_REG_SHADOW_EN

  reg_bank_t staging_q, staging_d;
  logic      vblank_q;
  logic      pending_q, pending_d;
  logic      transfer;

  // A write landing on the vblank-rise cycle counts as pending so that it is
  // carried into the same transfer instead of waiting a whole frame.
  assign transfer = vblank && !vblank_q && (pending_q || write_hit);

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves a signal unassigned and no latch is
  // inferred.
  always_comb begin
    staging_d = staging_q;
    if (write_hit) begin
      staging_d[addr] = (staging_q[addr] & ~lane_mask) | (data_in & lane_mask);
    end
    // Active takes the post-write staging value, merging a coincident write.
    active_d  = transfer ? staging_d : active_q;
    pending_d = pending_q;
    if (transfer) begin
      pending_d = 1'b0;
    end else if (write_hit) begin
      pending_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values of the others. The register banks are flops (not a
  // RAM macro) because both copies must clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging_q  <= '0;
      active_q   <= '0;
      vblank_q   <= 1'b0;
      pending_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      staging_q <= staging_d;
      active_q  <= active_d;
      vblank_q  <= vblank;
      pending_q <= pending_d;
      // Reads see the pre-write staging value on a same-address rd+wr.
      if (rd) begin
        data_out_q <= staging_q[addr];
      end
    end
  end

  assign update_pending = pending_q;

`else

  // vblank only matters for double buffering.
  logic unused_vblank;
  assign unused_vblank = vblank;

  always_comb begin
    active_d = active_q;
    if (write_hit) begin
      active_d[addr] = (active_q[addr] & ~lane_mask) | (data_in & lane_mask);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q   <= '0;
      data_out_q <= '0;
    end else begin
      active_q <= active_d;
      if (rd) begin
        data_out_q <= active_q[addr];
      end
    end
  end

  assign update_pending = 1'b0;

`endif

endmodule

// File: tb/tb_tile_reg_file.sv
module tb_tile_reg_file;

  logic         clk;
  logic         reset;
  logic [4:0]   addr;
  logic         wr;
  logic         rd;
  logic [1:0]   be;
  logic [15:0]  data_in;
  logic [15:0]  data_out;
  logic         vblank;
  logic [511:0] tile_reg_values;
  logic         update_pending;

  int checks;
  int errors;

  tile_reg_file dut (
    .clk             (clk),
    .reset           (reset),
    .addr            (addr),
    .wr              (wr),
    .rd              (rd),
    .be              (be),
    .data_in         (data_in),
    .data_out        (data_out),
    .vblank          (vblank),
    .tile_reg_values (tile_reg_values),
    .update_pending  (update_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] observed,
                       input logic [511:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] field(input int idx);
    return tile_reg_values[idx*16 +: 16];
  endfunction

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [15:0] d,
                           input logic [1:0] b);
    addr = a; data_in = d; be = b; wr = 1'b1;
    tick();
    wr = 1'b0; be = 2'b00;
  endtask

  task automatic bus_read(input logic [4:0] a);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; addr = '0; wr = 1'b0; rd = 1'b0; be = 2'b00;
    data_in = '0; vblank = 1'b0;
    #12;
    reset = 1'b0;
    tick();

    check("reset_trv", tile_reg_values, 512'h0);
    check("reset_pending", {511'h0, update_pending}, 512'h0);
    check("reset_dout", {496'h0, data_out}, 512'h0);

`ifdef TILE_REG_SHADOW_EN
    // Layer 1 OFFSET_X: staged, not yet active.
    bus_write(5'b01_101, 16'h1234, 2'b11);
    bus_read(5'b01_101);
    check("stage_read", {496'h0, data_out}, {496'h0, 16'h1234});
    check("stage_not_active", {496'h0, field(13)}, 512'h0);
    check("stage_pending", {511'h0, update_pending}, {511'h0, 1'b1});

    // vblank rise transfers staging to active.
    vblank = 1'b1;
    tick();
    check("xfer_field", {496'h0, field(13)}, {496'h0, 16'h1234});
    check("xfer_pending", {511'h0, update_pending}, 512'h0);

    // vblank held high: a new write must wait for the next rise.
    for (int i = 0; i < 50; i++) tick();
    bus_write(5'b01_101, 16'h5678, 2'b11);
    for (int i = 0; i < 50; i++) tick();
    check("held_field", {496'h0, field(13)}, {496'h0, 16'h1234});
    check("held_pending", {511'h0, update_pending}, {511'h0, 1'b1});
    vblank = 1'b0;
    tick();
    vblank = 1'b1;
    tick();
    check("rise2_field", {496'h0, field(13)}, {496'h0, 16'h5678});
    check("rise2_pending", {511'h0, update_pending}, 512'h0);
    vblank = 1'b0;
    tick();

    // Byte lanes.
    bus_write(5'd0, 16'hAABB, 2'b11);
    bus_write(5'd0, 16'h11CC, 2'b01);
    bus_read(5'd0);
    check("lane_read", {496'h0, data_out}, {496'h0, 16'hAACC});
    check("lane_not_active", {496'h0, field(0)}, 512'h0);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    check("lane_active", {496'h0, field(0)}, {496'h0, 16'hAACC});

    // be=00 leaves pending clear.
    bus_write(5'd0, 16'hFFFF, 2'b00);
    check("be0_pending", {511'h0, update_pending}, 512'h0);
    bus_read(5'd0);
    check("be0_read", {496'h0, data_out}, {496'h0, 16'hAACC});

    // Write coincident with vblank rise is merged into the transfer; the
    // same-cycle read returns the pre-write value.
    addr = 5'd31; data_in = 16'hBEEF; be = 2'b11; wr = 1'b1; rd = 1'b1;
    vblank = 1'b1;
    tick();
    wr = 1'b0; rd = 1'b0; be = 2'b00; vblank = 1'b0;
    check("merge_field", {496'h0, field(31)}, {496'h0, 16'hBEEF});
    check("merge_pending", {511'h0, update_pending}, 512'h0);
    check("merge_read_old", {496'h0, data_out}, 512'h0);

    // Pending write discarded by an asynchronous reset.
    bus_read(5'b01_101);
    bus_write(5'd5, 16'h0F0F, 2'b11);
    check("pre_reset_pending", {511'h0, update_pending}, {511'h0, 1'b1});
`else
    // Direct writes, vblank ignored.
    bus_write(5'd8, 16'h00FF, 2'b11);
    check("direct_field8", {496'h0, field(8)}, {496'h0, 16'h00FF});
    check("direct_pending", {511'h0, update_pending}, 512'h0);

    bus_write(5'b01_101, 16'h1234, 2'b11);
    check("direct_field13", {496'h0, field(13)}, {496'h0, 16'h1234});
    bus_read(5'b01_101);
    check("direct_read13", {496'h0, data_out}, {496'h0, 16'h1234});

    // Byte lanes.
    bus_write(5'd0, 16'hAABB, 2'b11);
    bus_write(5'd0, 16'h11CC, 2'b01);
    bus_read(5'd0);
    check("lane_read", {496'h0, data_out}, {496'h0, 16'hAACC});
    check("lane_field", {496'h0, field(0)}, {496'h0, 16'hAACC});
    bus_write(5'd0, 16'hFFFF, 2'b00);
    check("be0_field", {496'h0, field(0)}, {496'h0, 16'hAACC});
    bus_write(5'd0, 16'h9900, 2'b10);
    check("hi_lane_field", {496'h0, field(0)}, {496'h0, 16'h99CC});

    // Same-cycle rd+wr returns the old value; vblank has no effect.
    addr = 5'd31; data_in = 16'hBEEF; be = 2'b11; wr = 1'b1; rd = 1'b1;
    vblank = 1'b1;
    tick();
    wr = 1'b0; rd = 1'b0; be = 2'b00;
    check("rdwr_old", {496'h0, data_out}, 512'h0);
    check("rdwr_field31", {496'h0, field(31)}, {496'h0, 16'hBEEF});
    check("vblank_pending", {511'h0, update_pending}, 512'h0);
    vblank = 1'b0;

    // data_out holds while rd is low.
    bus_read(5'b01_101);
    tick(); tick(); tick();
    check("dout_hold", {496'h0, data_out}, {496'h0, 16'h1234});
`endif

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b1;
    #1;
    check("async_trv", tile_reg_values, 512'h0);
    check("async_dout", {496'h0, data_out}, 512'h0);
    check("async_pending", {511'h0, update_pending}, 512'h0);
    tick();
    reset = 1'b0;
    tick();
    vblank = 1'b1;
    tick();
    tick();
    vblank = 1'b0;
    check("post_reset_vblank", tile_reg_values, 512'h0);
    check("post_reset_pending", {511'h0, update_pending}, 512'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
